fork_join_ctrl: RTL and testbench
=================================

Name: fork_join_ctrl

Overview:
- Hardware fork/join dispatcher with a parametrised child count.
- A parent issues a fork request with a channel mask and a join mode. The block pulses start to each selected child, then tracks each child's done pulse as a sticky event.
- It reports back to the parent when the join condition is met:
  - JOIN_ALL: every selected child has completed.
  - JOIN_ANY: any selected child has completed.
  - JOIN_NONE: report immediately after launch.
- It also provides a wait-fork barrier over all outstanding children and an optional watchdog timeout. It sits between a sequencing master and N worker engines.

Parameters:
- N_CHILD, 3, number of child channels (2..16).
- TAG_W, 8, width of the fork tag, broadcast to children and echoed at join.
- TIMEOUT_CYC, 0, WAIT-state watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fork_valid  in  1  fork request valid.
- fork_ready  out  1  fork request can be accepted.
- fork_mode  in  2  0=JOIN_ALL, 1=JOIN_ANY, 2=JOIN_NONE, 3=reserved (treated as JOIN_ALL).
- fork_mask  in  N_CHILD  children to launch.
- fork_tag  in  TAG_W  request identifier.
- child_start  out  N_CHILD  one-cycle start pulse per launched child.
- child_tag  out  TAG_W  tag of the current launch, valid with child_start.
- child_done  in  N_CHILD  one-cycle completion pulse per child.
- join_valid  out  1  join report valid.
- join_ready  in  1  parent accepts the report.
- join_tag  out  TAG_W  echoed fork_tag.
- join_done_mask  out  N_CHILD  children of this fork completed at report time.
- join_first_id  out  $clog2(N_CHILD)  first completing child; lowest index on a tie.
- join_timeout  out  1  report caused by the watchdog.
- wait_req  in  1  pulse: request a barrier on all outstanding children.
- wait_done  out  1  one-cycle pulse when the barrier is satisfied.
- busy  out  1  FSM not in IDLE, or any child outstanding.

Behaviour:
- Reset:
  - All outputs are 0, except fork_ready, which is 1 the first cycle after rst_n deasserts.
  - State goes to IDLE; the outstanding and done registers are cleared.
  - A pending wait_req is dropped.
  - Child pulses arriving during reset are lost.
- Outstanding register (N_CHILD bits):
  - A bit sets on fork acceptance for each mask bit.
  - A bit clears on child_done for that channel.
  - child_done on a non-outstanding channel is ignored.
- fork_ready is 1 only when the state is IDLE and (fork_mask & outstanding)==0. A new fork never reuses a still-running child.
- FSM states: IDLE, LAUNCH, WAIT, REPORT.
  - IDLE -> LAUNCH on fork_valid & fork_ready. At that edge the block latches mode, mask and tag, and clears the done register.
  - LAUNCH (1 cycle): child_start = mask, child_tag = tag.
    - JOIN_NONE, or mask==0: go to REPORT.
    - Otherwise: go to WAIT.
  - WAIT: the done register ORs in child_done & mask each cycle, counting from the LAUNCH cycle onward.
    - The first cycle in which any masked done arrives latches join_first_id via the priority encoder.
    - JOIN_ALL exits when done==mask; JOIN_ANY exits when done!=0. The exit is evaluated on the registered done set, so REPORT follows one cycle after the satisfying pulse.
    - Watchdog: counts WAIT cycles. When the count reaches TIMEOUT_CYC (if nonzero), go to REPORT with join_timeout=1.
  - REPORT: join_valid=1, with all join_* outputs stable until join_ready. On the join_valid & join_ready edge the FSM returns to IDLE.
    - Children still outstanding after JOIN_ANY, JOIN_NONE or timeout stay outstanding and keep being tracked.
    - join_done_mask and join_first_id are 0 when nothing completed.
- Latency: minimum from accept to join_valid is 2 cycles (JOIN_NONE).
- Wait barrier:
  - wait_req sets a sticky pending flag.
  - wait_done pulses on the first cycle in which pending is set and outstanding==0, including the same cycle as the request. Pending then clears.
  - Operates independently of the FSM.
- Simultaneous events:
  - child_done in the same cycle as acceptance of a new fork on a disjoint mask is applied to the old outstanding bit only.
  - Multiple dones in one cycle are all recorded.

Decomposition:
- Package fork_join_pkg:
  - join_mode_e enum (JOIN_ALL, JOIN_ANY, JOIN_NONE).
  - fj_state_e enum.
  - localparam MODE_W=2.
- Sub-module fj_prio_enc: parametrised lowest-index one-hot/any-bit priority encoder, used for join_first_id.

Test Plan:
- N=3, JOIN_ALL, mask=111, tag=0x5A; done ch0 @+3, ch2 @+5, ch1 @+8 -> join_valid @+9, done_mask=111, first_id=0, tag=0x5A.
- JOIN_ANY, mask=111; ch1 and ch2 done in the same cycle -> first_id=1, done_mask=110; then fork mask=001 holds fork_ready=0 until ch0 done, accepted the cycle after.
- JOIN_NONE, mask=011 -> join_valid 2 cycles after accept, done_mask=000; wait_req then ch0 @+4, ch1 @+6 -> wait_done pulse @+6 exactly once.
- TIMEOUT_CYC=8, JOIN_ALL, mask=111, ch2 never done -> join_timeout=1 after 8 WAIT cycles, done_mask=011; ch2 remains outstanding and busy=1.
- join_ready held 0 for 5 cycles in REPORT -> all join_* outputs stable; a late child_done does not alter done_mask once REPORT is entered.
- Assert rst_n mid-WAIT with 2 children outstanding -> outputs 0 immediately, outstanding=0, fork_ready=1 in the first cycle after release, mask=111 fork accepted.

Source files
------------

// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join dispatcher: join modes, FSM states and
// the mode decoder that folds the reserved encoding onto JOIN_ALL.
package fork_join_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_REPORT
  } fj_state_e;

  function automatic join_mode_e decode_mode(input logic [MODE_W-1:0] mode);
    case (mode)
      2'd1:    return JOIN_ANY;
      2'd2:    return JOIN_NONE;
      default: return JOIN_ALL;
    endcase
  endfunction

endpackage

// File: rtl/fj_prio_enc.sv
// Lowest-index priority encoder: idx is the lowest set bit of req,
// any flags that at least one bit is set (idx is 0 when none is).
module fj_prio_enc #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join dispatcher: launches selected children, tracks their completion
// and reports to the parent under JOIN_ALL / JOIN_ANY / JOIN_NONE rules.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a fork whose mask is disjoint from outstanding
// ST_LAUNCH | one cycle: child_start pulses, done collection begins
// ST_WAIT   | collecting child_done until the join rule or watchdog fires
// ST_REPORT | join_valid held with frozen join_* until join_ready
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter  int N_CHILD     = 3,
  parameter  int TAG_W       = 8,
  parameter  int TIMEOUT_CYC = 0,
  localparam int ID_W        = $clog2(N_CHILD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fork_valid,
  output logic               fork_ready,
  input  logic [MODE_W-1:0]  fork_mode,
  input  logic [N_CHILD-1:0] fork_mask,
  input  logic [TAG_W-1:0]   fork_tag,
  output logic [N_CHILD-1:0] child_start,
  output logic [TAG_W-1:0]   child_tag,
  input  logic [N_CHILD-1:0] child_done,
  output logic               join_valid,
  input  logic               join_ready,
  output logic [TAG_W-1:0]   join_tag,
  output logic [N_CHILD-1:0] join_done_mask,
  output logic [ID_W-1:0]    join_first_id,
  output logic               join_timeout,
  input  logic               wait_req,
  output logic               wait_done,
  output logic               busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  fj_state_e          state_q, state_d;
  join_mode_e         mode_q, mode_d;
  logic [N_CHILD-1:0] mask_q, mask_d;
  logic [N_CHILD-1:0] out_q, out_d;
  logic [N_CHILD-1:0] done_q, done_d;
  logic [N_CHILD-1:0] start_q, start_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [ID_W-1:0]    first_q, first_d;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic               jvalid_q, jvalid_d;
  logic               tmo_q, tmo_d;
  logic               pend_q, pend_d;

  logic               accept;
  logic               tracking;
  logic [N_CHILD-1:0] hit;
  logic [ID_W-1:0]    hit_id;
  logic               hit_any;
  logic               join_met;
  logic               wd_expire;
  logic               wait_hit;

  // rst_n gating keeps the combinational outputs quiet while held in reset.
  assign fork_ready = rst_n && (state_q == ST_IDLE) && ((fork_mask & out_q) == '0);
  assign accept     = fork_valid && fork_ready;
  assign tracking   = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign hit        = tracking ? (child_done & mask_q) : '0;

  fj_prio_enc #(.N(N_CHILD)) u_first_enc (
    .req (hit),
    .idx (hit_id),
    .any (hit_any)
  );

  // Barrier looks at outstanding after this cycle's done pulses retire.
  assign wait_hit  = rst_n && (pend_q || wait_req) && ((out_q & ~child_done) == '0);
  assign wait_done = wait_hit;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    tag_d     = tag_q;
    tmo_d     = tmo_q;
    jvalid_d  = jvalid_q;
    wd_d      = wd_q;
    start_d   = '0;
    done_d    = done_q | hit;
    first_d   = (hit_any && (done_q == '0)) ? hit_id : first_q;
    out_d     = (out_q & ~child_done) | (accept ? fork_mask : '0);
    pend_d    = (pend_q || wait_req) && !wait_hit;
    join_met  = (mode_q == JOIN_ANY) ? (done_d != '0) : (done_d == mask_q);
    wd_expire = (TIMEOUT_CYC != 0) && (wd_q == CNT_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LAUNCH;
          mode_d  = decode_mode(fork_mode);
          mask_d  = fork_mask;
          tag_d   = fork_tag;
          done_d  = '0;
          first_d = '0;
          tmo_d   = 1'b0;
          start_d = fork_mask;
        end
      end
      ST_LAUNCH: begin
        wd_d = CNT_W'(TIMEOUT_CYC);
        if ((mode_q == JOIN_NONE) || (mask_q == '0)) begin
          state_d  = ST_REPORT;
          jvalid_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wd_q != '0) wd_d = wd_q - CNT_W'(1);
        // A satisfied join beats a watchdog expiring in the same cycle.
        if (join_met) begin
          state_d  = ST_REPORT;
          jvalid_d = 1'b1;
        end else if (wd_expire) begin
          state_d  = ST_REPORT;
          jvalid_d = 1'b1;
          tmo_d    = 1'b1;
        end
      end
      ST_REPORT: begin
        if (join_ready) begin
          state_d  = ST_IDLE;
          jvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= JOIN_ALL;
      mask_q   <= '0;
      out_q    <= '0;
      done_q   <= '0;
      start_q  <= '0;
      tag_q    <= '0;
      first_q  <= '0;
      wd_q     <= '0;
      jvalid_q <= 1'b0;
      tmo_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      out_q    <= out_d;
      done_q   <= done_d;
      start_q  <= start_d;
      tag_q    <= tag_d;
      first_q  <= first_d;
      wd_q     <= wd_d;
      jvalid_q <= jvalid_d;
      tmo_q    <= tmo_d;
      pend_q   <= pend_d;
    end
  end

  assign child_start    = start_q;
  assign child_tag      = tag_q;
  assign join_valid     = jvalid_q;
  assign join_tag       = tag_q;
  assign join_done_mask = done_q;
  assign join_first_id  = first_q;
  assign join_timeout   = tmo_q;
  assign busy           = (state_q != ST_IDLE) || (out_q != '0);

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Bench for fork_join_ctrl (N_CHILD=3, TIMEOUT_CYC=8): scenario table,
// hand-written corner sequences, then random traffic against a timing model.
`timescale 1ns/1ps
module tb_fork_join_ctrl;

  localparam int N   = 3;
  localparam int TW  = 8;
  localparam int TMO = 8;
  localparam int IW  = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fork_valid, fork_ready;
  logic [1:0]    fork_mode;
  logic [N-1:0]  fork_mask;
  logic [TW-1:0] fork_tag;
  logic [N-1:0]  child_start;
  logic [TW-1:0] child_tag;
  logic [N-1:0]  child_done;
  logic          join_valid, join_ready;
  logic [TW-1:0] join_tag;
  logic [N-1:0]  join_done_mask;
  logic [IW-1:0] join_first_id;
  logic          join_timeout;
  logic          wait_req, wait_done, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fork_join_ctrl #(.N_CHILD(N), .TAG_W(TW), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fork_valid     (fork_valid),
    .fork_ready     (fork_ready),
    .fork_mode      (fork_mode),
    .fork_mask      (fork_mask),
    .fork_tag       (fork_tag),
    .child_start    (child_start),
    .child_tag      (child_tag),
    .child_done     (child_done),
    .join_valid     (join_valid),
    .join_ready     (join_ready),
    .join_tag       (join_tag),
    .join_done_mask (join_done_mask),
    .join_first_id  (join_first_id),
    .join_timeout   (join_timeout),
    .wait_req       (wait_req),
    .wait_done      (wait_done),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    fork_valid = 1'b0; fork_mode = 2'd0; fork_mask = '0; fork_tag = '0;
    child_done = '0; join_ready = 1'b0; wait_req = 1'b0;
  endtask

  // Next cycle: move to the negedge and drop all one-cycle pulse inputs.
  task automatic nxt();
    @(negedge clk);
    fork_valid = 1'b0; child_done = '0; wait_req = 1'b0;
  endtask

  // Scenario table: accept at cycle 0, dly = cycle of each child's done (-1 never),
  // e_lat = cycle join_valid rises, e_busy = busy the cycle after the handshake.
  typedef struct {
    int mode; int mask; int tag; int dly[N];
    int e_mask; int e_first; int e_tmo; int e_lat; int e_busy;
  } vec_t;
  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int w;
    w = v.e_lat;
    for (int i = 0; i < N; i++) if (v.dly[i] > w) w = v.dly[i];
    w += 2;
    for (int c = 0; c <= w; c++) begin
      @(negedge clk);
      fork_valid = (c == 0);
      fork_mode  = 2'(v.mode);
      fork_mask  = N'(v.mask);
      fork_tag   = TW'(v.tag);
      join_ready = 1'b1;
      for (int i = 0; i < N; i++) child_done[i] = (v.dly[i] == c);
      #1;
      if (c == 0) chk($sformatf("v%0d fork_ready", idx), 32'(fork_ready), 32'(1));
      if (c == 1) begin
        chk($sformatf("v%0d child_start", idx), 32'(child_start), 32'(v.mask));
        if (v.mask != 0) chk($sformatf("v%0d child_tag", idx), 32'(child_tag), 32'(v.tag));
      end
      if (c == v.e_lat - 1) chk($sformatf("v%0d join_valid early", idx), 32'(join_valid), 32'(0));
      if (c == v.e_lat) begin
        chk($sformatf("v%0d join_valid", idx), 32'(join_valid), 32'(1));
        chk($sformatf("v%0d join_tag", idx), 32'(join_tag), 32'(v.tag));
        chk($sformatf("v%0d join_done_mask", idx), 32'(join_done_mask), 32'(v.e_mask));
        chk($sformatf("v%0d join_first_id", idx), 32'(join_first_id), 32'(v.e_first));
        chk($sformatf("v%0d join_timeout", idx), 32'(join_timeout), 32'(v.e_tmo));
      end
      if (c == v.e_lat + 1) chk($sformatf("v%0d busy after join", idx), 32'(busy), 32'(v.e_busy));
    end
    @(negedge clk);
    fork_valid = 1'b0; fork_mask = '0; child_done = '1;
    @(negedge clk);
    child_done = '0;
    #1;
    chk($sformatf("v%0d drained busy", idx), 32'(busy), 32'(0));
  endtask

  // Random-phase reference model: per-fork record of done arrival times.
  bit            f_active, f_tmo, m_pend;
  int            f_acc, f_rep;
  int            f_mode;
  logic [N-1:0]  f_mask, m_out, e_start, e_dm;
  logic [TW-1:0] f_tag;
  int            f_dt[N];
  int            sched[N];
  bit            e_ready, e_wd, e_busy, e_jv, acc, cond, none;
  int            e_fi, best;

  initial begin
    idle_in();
    vecs[0] = '{0, 7, 'h5A, '{3, 8, 5},   7, 0, 0,  9, 0};
    vecs[1] = '{1, 7, 'h33, '{-1, 4, 4},  6, 1, 0,  5, 1};
    vecs[2] = '{2, 3, 'hC3, '{4, 6, -1},  0, 0, 0,  2, 1};
    vecs[3] = '{0, 7, 'hE1, '{2, 3, -1},  3, 0, 1, 10, 1};
    vecs[4] = '{0, 0, 'h11, '{-1, -1, -1},0, 0, 0,  2, 0};
    vecs[5] = '{3, 5, 'h2B, '{1, -1, 2},  5, 0, 0,  3, 0};
    vecs[6] = '{1, 6, 'h64, '{-1, 1, 1},  6, 1, 0,  3, 0};
    vecs[7] = '{1, 5, 'h7E, '{6, -1, 3},  4, 2, 0,  4, 1};
    vecs[8] = '{0, 2, 'h90, '{-1, 9, -1}, 2, 1, 0, 10, 0};
    vecs[9] = '{0, 1, 'hA5, '{10, -1, -1},0, 0, 1, 10, 0};

    // Reset: outputs quiet while held, fork_ready up the first cycle after release.
    @(negedge clk);
    wait_req = 1'b1; fork_mask = 3'b111;
    #1;
    chk("rst fork_ready", 32'(fork_ready), 32'(0));
    chk("rst wait_done", 32'(wait_done), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst join_valid", 32'(join_valid), 32'(0));
    nxt();
    rst_n = 1'b1; fork_mask = 3'b111;
    #1;
    chk("post-rst fork_ready", 32'(fork_ready), 32'(1));
    chk("post-rst child_start", 32'(child_start), 32'(0));
    chk("post-rst join_done_mask", 32'(join_done_mask), 32'(0));
    chk("post-rst join_timeout", 32'(join_timeout), 32'(0));

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // JOIN_ANY with a tie, then a fork blocked on the still-running child.
    nxt(); fork_valid = 1'b1; fork_mode = 2'd1; fork_mask = 3'b111; fork_tag = 8'h21; join_ready = 1'b1; #1;
    nxt(); #1;
    nxt(); #1;
    nxt(); child_done = 3'b110; #1;
    nxt(); #1;
    chk("any join_valid", 32'(join_valid), 32'(1));
    chk("any done_mask", 32'(join_done_mask), 32'(6));
    chk("any first_id", 32'(join_first_id), 32'(1));
    nxt(); fork_mask = 3'b110; #1;
    chk("disjoint fork_ready", 32'(fork_ready), 32'(1));
    repeat (2) begin
      nxt(); fork_valid = 1'b1; fork_mask = 3'b001; fork_mode = 2'd0; fork_tag = 8'h44; #1;
      chk("blocked fork_ready", 32'(fork_ready), 32'(0));
    end
    nxt(); fork_valid = 1'b1; child_done = 3'b001; #1;
    chk("blocked fork_ready at done", 32'(fork_ready), 32'(0));
    nxt(); fork_valid = 1'b1; #1;
    chk("unblocked fork_ready", 32'(fork_ready), 32'(1));
    nxt(); #1;
    chk("reuse child_start", 32'(child_start), 32'(1));
    chk("reuse child_tag", 32'(child_tag), 32'('h44));
    nxt(); child_done = 3'b001; #1;
    nxt(); #1;
    chk("reuse join_valid", 32'(join_valid), 32'(1));
    chk("reuse done_mask", 32'(join_done_mask), 32'(1));
    nxt(); #1;
    chk("reuse busy", 32'(busy), 32'(0));

    // Wait barrier: immediate when idle, then over a JOIN_NONE fork.
    nxt(); wait_req = 1'b1; #1;
    chk("barrier immediate", 32'(wait_done), 32'(1));
    nxt(); #1;
    chk("barrier cleared", 32'(wait_done), 32'(0));
    nxt(); fork_valid = 1'b1; fork_mode = 2'd2; fork_mask = 3'b011; fork_tag = 8'hC3; #1;
    nxt(); #1;
    nxt(); #1;
    chk("none join_valid", 32'(join_valid), 32'(1));
    chk("none done_mask", 32'(join_done_mask), 32'(0));
    for (int c = 3; c <= 9; c++) begin
      nxt();
      if (c == 3) wait_req = 1'b1;
      if (c == 4) child_done = 3'b001;
      if (c == 6) child_done = 3'b010;
      #1;
      chk($sformatf("barrier c%0d", c), 32'(wait_done), 32'(c == 6));
    end

    // REPORT held by join_ready=0; a late done must not leak into the report.
    nxt(); fork_valid = 1'b1; fork_mode = 2'd1; fork_mask = 3'b011; fork_tag = 8'h5C; join_ready = 1'b0; #1;
    nxt(); #1;
    nxt(); child_done = 3'b001; #1;
    for (int c = 3; c <= 7; c++) begin
      nxt();
      if (c == 5) child_done = 3'b010;
      #1;
      chk($sformatf("hold valid c%0d", c), 32'(join_valid), 32'(1));
      chk($sformatf("hold tag c%0d", c), 32'(join_tag), 32'('h5C));
      chk($sformatf("hold done_mask c%0d", c), 32'(join_done_mask), 32'(1));
      chk($sformatf("hold first_id c%0d", c), 32'(join_first_id), 32'(0));
      chk($sformatf("hold timeout c%0d", c), 32'(join_timeout), 32'(0));
    end
    nxt(); join_ready = 1'b1; #1;
    chk("hold release valid", 32'(join_valid), 32'(1));
    nxt(); #1;
    chk("hold after valid", 32'(join_valid), 32'(0));
    chk("hold after busy", 32'(busy), 32'(0));

    // Reset asserted mid-WAIT with two children outstanding.
    nxt(); fork_valid = 1'b1; fork_mode = 2'd0; fork_mask = 3'b111; fork_tag = 8'h77; #1;
    nxt(); #1;
    nxt(); child_done = 3'b001; #1;
    nxt(); #1;
    nxt(); wait_req = 1'b1; #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'(0));
    chk("midrst join_done_mask", 32'(join_done_mask), 32'(0));
    chk("midrst join_tag", 32'(join_tag), 32'(0));
    chk("midrst fork_ready", 32'(fork_ready), 32'(0));
    chk("midrst wait_done", 32'(wait_done), 32'(0));
    repeat (2) begin
      nxt(); child_done = 3'b010; wait_req = 1'b1; #1;
      chk("in-rst busy", 32'(busy), 32'(0));
    end
    nxt(); rst_n = 1'b1; fork_valid = 1'b1; fork_mask = 3'b111; fork_tag = 8'h99; #1;
    chk("rel fork_ready", 32'(fork_ready), 32'(1));
    chk("rel busy", 32'(busy), 32'(0));
    nxt(); #1;
    chk("rel child_start", 32'(child_start), 32'(7));
    nxt(); child_done = 3'b111; #1;
    nxt(); #1;
    chk("rel join_valid", 32'(join_valid), 32'(1));
    chk("rel done_mask", 32'(join_done_mask), 32'(7));

    // Random traffic against the model, from a clean reset.
    nxt(); idle_in(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    f_active = 1'b0; f_tmo = 1'b0; m_pend = 1'b0; m_out = '0;
    f_acc = 0; f_rep = -1; f_mode = 0; f_mask = '0; f_tag = '0;
    for (int i = 0; i < N; i++) begin sched[i] = -1; f_dt[i] = -1; end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (f_active && f_rep < 0) begin
        none = (f_mode == 2) || (f_mask == '0);
        if (none) begin
          if (c == f_acc + 2) f_rep = c;
        end else begin
          cond = (f_mode != 1);
          for (int i = 0; i < N; i++) begin
            if (f_mask[i]) begin
              if (f_mode == 1) cond = cond || (f_dt[i] >= 0);
              else             cond = cond && (f_dt[i] >= 0);
            end
          end
          if (c >= f_acc + 3 && cond) f_rep = c;
          else if (c == f_acc + 2 + TMO) begin f_rep = c; f_tmo = 1'b1; end
        end
      end
      e_start = (f_active && c == f_acc + 1) ? f_mask : '0;
      for (int i = 0; i < N; i++) begin
        if (e_start[i]) sched[i] = ($urandom_range(0, 7) == 0) ? c + $urandom_range(12, 25)
                                                               : c + $urandom_range(0, 9);
      end
      for (int i = 0; i < N; i++) begin
        child_done[i] = 1'b0;
        if (sched[i] == c) begin child_done[i] = 1'b1; sched[i] = -1; end
        else if (!m_out[i] && $urandom_range(0, 15) == 0) child_done[i] = 1'b1;
      end
      fork_valid = ($urandom_range(0, 1) == 1);
      fork_mode  = 2'($urandom_range(0, 3));
      fork_mask  = N'($urandom_range(0, 7));
      fork_tag   = TW'($urandom_range(0, 255));
      join_ready = ($urandom_range(0, 3) != 0);
      wait_req   = ($urandom_range(0, 11) == 0);

      e_ready = !f_active && ((fork_mask & m_out) == '0);
      e_wd    = (m_pend || wait_req) && ((m_out & ~child_done) == '0);
      e_busy  = f_active || (m_out != '0);
      e_jv    = f_active && (f_rep >= 0);
      #1;
      chk("rnd fork_ready", 32'(fork_ready), 32'(e_ready));
      chk("rnd child_start", 32'(child_start), 32'(e_start));
      chk("rnd busy", 32'(busy), 32'(e_busy));
      chk("rnd wait_done", 32'(wait_done), 32'(e_wd));
      chk("rnd join_valid", 32'(join_valid), 32'(e_jv));
      if (e_start != '0) chk("rnd child_tag", 32'(child_tag), 32'(f_tag));
      if (e_jv) begin
        e_dm = '0; e_fi = 0; best = 1 << 30;
        for (int i = 0; i < N; i++) begin
          if (f_mask[i] && f_dt[i] >= 0 && f_dt[i] < f_rep) begin
            e_dm[i] = 1'b1;
            if (f_dt[i] < best) begin best = f_dt[i]; e_fi = i; end
          end
        end
        chk("rnd join_tag", 32'(join_tag), 32'(f_tag));
        chk("rnd join_done_mask", 32'(join_done_mask), 32'(e_dm));
        chk("rnd join_first_id", 32'(join_first_id), 32'(e_fi));
        chk("rnd join_timeout", 32'(join_timeout), 32'(f_tmo));
      end

      if (f_active && f_rep < 0 && c >= f_acc + 1) begin
        for (int i = 0; i < N; i++)
          if (f_mask[i] && child_done[i] && f_dt[i] < 0) f_dt[i] = c;
      end
      acc = fork_valid && e_ready;
      if (e_jv && join_ready) f_active = 1'b0;
      m_out  = (m_out & ~child_done) | (acc ? fork_mask : '0);
      m_pend = (m_pend || wait_req) && !e_wd;
      if (acc) begin
        f_active = 1'b1; f_acc = c; f_rep = -1; f_tmo = 1'b0;
        f_mode = int'(fork_mode); f_mask = fork_mask; f_tag = fork_tag;
        for (int i = 0; i < N; i++) f_dt[i] = -1;
      end
    end

    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
